mac_tanh_sequencer: RTL and testbench
=====================================

Name: mac_tanh_sequencer

Overview:
- Controller that sequences the fixed-point MAC and tanh-interpolation datapath across a full matrix-vector job.
- For each input vector v and output row r, it:
  - streams VEC_LEN x elements from SRAM and VEC_LEN g weights from gmem;
  - drives the MAC accumulate/clear strobes;
  - launches one tanh interpolation and waits for its result;
  - writes the 16-bit result back to SRAM.
- Sits between the top-level run/busy control and the MAC/tanh datapath.

Parameters:
- ADDR_W, 12: width of all memory addresses.
- VEC_LEN, 16: elements per dot product.
- NUM_ROWS, 16: g rows, i.e. outputs per input vector.
- NUM_VECS, 16: input x vectors per job.
- X_BASE, 12'h000: SRAM byte address of x vector 0.
- G_BASE, 12'h000: gmem byte address of g row 0.
- OUT_BASE, 12'h200: SRAM byte address of output 0.

Ports:
- clk, in, 1: single clock; all logic rising-edge.
- reset, in, 1: synchronous, active-high reset.
- run, in, 1: job start request, sampled in IDLE only.
- busy, out, 1: high while a job is in progress.
- done, out, 1: one-cycle pulse at job end.
- sram_rd_addr, out, ADDR_W: x read address, registered.
- gmem_rd_addr, out, ADDR_W: g read address, registered.
- mac_en, out, 1: product of this cycle's read data is valid.
- mac_clear, out, 1: with mac_en, load the accumulator instead of adding to it.
- tanh_start, out, 1: one-cycle pulse; accumulator is final.
- tanh_done, in, 1: tanh result valid (pulse).
- tanh_result, in, 16: Q-format tanh output.
- sram_wr_en, out, 1: write strobe.
- sram_wr_addr, out, ADDR_W: write address.
- sram_wr_data, out, 16: write data.

Behaviour:
- Reset: synchronous; effective on the clock edge where reset=1, including mid-job.
  - State goes to IDLE; all counters clear.
  - busy=0, done=0, mac_en=0, mac_clear=0, tanh_start=0, sram_wr_en=0.
  - All addresses and sram_wr_data = 0.
  - Any partial result is discarded and no write occurs.
- Counters:
  - v in 0..NUM_VECS-1, r in 0..NUM_ROWS-1, k in 0..VEC_LEN-1.
  - Addresses step by 2 (byte-addressed 16-bit words).
- Address formulas, mod 2^ADDR_W (wrap silently):
  - sram_rd_addr = X_BASE + 2*(v*VEC_LEN + k)
  - gmem_rd_addr = G_BASE + 2*(r*VEC_LEN + k)
  - sram_wr_addr = OUT_BASE + 2*(v*NUM_ROWS + r)
- States:
  - IDLE:
    - run=1 -> FETCH with k=0, v=0, r=0; busy=1 from the next cycle.
    - run=0 -> stay.
  - FETCH:
    - Each cycle presents the addresses for element k.
    - Memories return data one cycle later.
    - k=VEC_LEN-1 -> DRAIN; otherwise k++.
  - DRAIN: one cycle, covering the return of the last element -> TANH_REQ.
  - MAC strobes (span FETCH and DRAIN):
    - mac_en=1 in the cycle after every FETCH cycle, i.e. exactly VEC_LEN cycles per row, the last one in DRAIN.
    - mac_clear=1 only together with the first mac_en of a row.
  - TANH_REQ: tanh_start=1 for one cycle -> WAIT_TANH.
  - WAIT_TANH:
    - On tanh_done=1, capture tanh_result into sram_wr_data -> WRITE.
    - tanh_done in any other state is ignored.
  - WRITE: sram_wr_en=1 for exactly one cycle with sram_wr_addr/sram_wr_data stable. Then:
    - r<NUM_ROWS-1: r++, k=0 -> FETCH.
    - else if v<NUM_VECS-1: v++, r=0, k=0 -> FETCH.
    - else -> DONE.
  - DONE: done=1, busy=0 for one cycle -> IDLE.
- busy is high from the cycle after run is accepted through the final WRITE cycle inclusive.
- run asserted while busy=1 or in DONE is ignored; it is never queued.
- Per-row latency: VEC_LEN + 3 + tanh latency cycles (FETCH..WRITE).
- No SRAM read and write ever occur in the same cycle. Reads happen only in FETCH; writes only in WRITE.

Optional Feature:
- Macro: MAC_TANH_SEQ_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles [15:0], which counts cycles spent in WAIT_TANH during the current job.
  - Cleared when run is accepted; holds its value after DONE; saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package mac_tanh_pkg holds:
  - state enum: IDLE, FETCH, DRAIN, TANH_REQ, WAIT_TANH, WRITE, DONE;
  - ADDR_W, WORD_BYTES=2;
  - default base-address constants.
- One sub-module, mac_tanh_addr_gen: holds the k/r/v counters and computes the three addresses. The FSM stays in the top.

Test Plan:
- Minimal job, VEC_LEN=2, NUM_ROWS=1, NUM_VECS=1; run pulse; tanh_done 3 cycles after tanh_start with tanh_result=16'h1234:
  - sram_rd_addr sequence 0,2;
  - mac_en on 2 cycles, mac_clear on the first;
  - one write of 16'h1234 at 12'h200;
  - done pulse; busy low in the same cycle.
- Defaults, tanh_done 1 cycle after each start:
  - exactly 256 writes, addresses 12'h200..12'h3FE step 2, in order;
  - gmem_rd_addr restarts at 0 on each new v.
- reset=1 asserted mid-WAIT_TANH, then tanh_done=1:
  - no write occurs;
  - all outputs at reset values next cycle;
  - a later run restarts at v=0, r=0.
- run held high for the whole job: exactly one job executes; after DONE and IDLE, a new job starts.
- Spurious tanh_done=1 during FETCH: ignored; write count and data unchanged.
- With MAC_TANH_SEQ_PERF_EN, tanh latency 5, VEC_LEN=2, NUM_ROWS=2, NUM_VECS=1: perf_stall_cycles=10 after done.

Source files
------------

// File: rtl/mac_tanh_pkg.sv
// Shared types and defaults for the MAC/tanh job sequencer.
package mac_tanh_pkg;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned WORD_BYTES = 2;

  localparam logic [ADDR_W-1:0] X_BASE_DEF   = 12'h000;
  localparam logic [ADDR_W-1:0] G_BASE_DEF   = 12'h000;
  localparam logic [ADDR_W-1:0] OUT_BASE_DEF = 12'h200;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StTanhReq,
    StWaitTanh,
    StWrite,
    StDone
  } state_e;

  // Byte address of 16-bit word idx; caller truncates to the address width.
  function automatic int unsigned word_addr(int unsigned base, int unsigned idx);
    return base + idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/mac_tanh_addr_gen.sv
// k/r/v loop counters and the registered x-read, g-read and result-write addresses.
module mac_tanh_addr_gen #(
  parameter int unsigned        ADDR_W   = mac_tanh_pkg::ADDR_W,
  parameter int unsigned        VEC_LEN  = 16,
  parameter int unsigned        NUM_ROWS = 16,
  parameter int unsigned        NUM_VECS = 16,
  parameter logic [ADDR_W-1:0]  X_BASE   = mac_tanh_pkg::X_BASE_DEF,
  parameter logic [ADDR_W-1:0]  G_BASE   = mac_tanh_pkg::G_BASE_DEF,
  parameter logic [ADDR_W-1:0]  OUT_BASE = mac_tanh_pkg::OUT_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_clr,
  input  logic              k_step,
  input  logic              row_next,
  output logic              k_first,
  output logic              k_last,
  output logic              r_last,
  output logic              v_last,
  output logic [ADDR_W-1:0] sram_rd_addr,
  output logic [ADDR_W-1:0] gmem_rd_addr,
  output logic [ADDR_W-1:0] sram_wr_addr
);
  import mac_tanh_pkg::*;

  localparam int unsigned KW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned VW = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1;

  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] r_q, r_d;
  logic [VW-1:0] v_q, v_d;
  logic [ADDR_W-1:0] x_addr_q, x_addr_d;
  logic [ADDR_W-1:0] g_addr_q, g_addr_d;
  logic [ADDR_W-1:0] o_addr_q, o_addr_d;

  assign k_first = (k_q == '0);
  assign k_last  = (k_q == KW'(VEC_LEN - 1));
  assign r_last  = (r_q == RW'(NUM_ROWS - 1));
  assign v_last  = (v_q == VW'(NUM_VECS - 1));

  always_comb begin
    k_d = k_q;
    r_d = r_q;
    v_d = v_q;
    if (cnt_clr) begin
      k_d = '0;
      r_d = '0;
      v_d = '0;
    end else if (k_step) begin
      k_d = k_q + 1'b1;
    end else if (row_next) begin
      k_d = '0;
      if (r_last) begin
        r_d = '0;
        if (!v_last) v_d = v_q + 1'b1;
      end else begin
        r_d = r_q + 1'b1;
      end
    end
  end

  // Addresses follow the next counter values so they are valid in the cycle the counters are.
  always_comb begin
    x_addr_d = ADDR_W'(word_addr(32'(X_BASE), 32'(v_d) * VEC_LEN + 32'(k_d)));
    g_addr_d = ADDR_W'(word_addr(32'(G_BASE), 32'(r_d) * VEC_LEN + 32'(k_d)));
    o_addr_d = ADDR_W'(word_addr(32'(OUT_BASE), 32'(v_d) * NUM_ROWS + 32'(r_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q      <= '0;
      r_q      <= '0;
      v_q      <= '0;
      x_addr_q <= '0;
      g_addr_q <= '0;
      o_addr_q <= '0;
    end else begin
      k_q <= k_d;
      r_q <= r_d;
      v_q <= v_d;
      if (cnt_clr || k_step || row_next) begin
        x_addr_q <= x_addr_d;
        g_addr_q <= g_addr_d;
        o_addr_q <= o_addr_d;
      end
    end
  end

  assign sram_rd_addr = x_addr_q;
  assign gmem_rd_addr = g_addr_q;
  assign sram_wr_addr = o_addr_q;

endmodule

// File: rtl/mac_tanh_sequencer.sv
// Job-level FSM sequencing MAC accumulation, tanh interpolation and result write-back.
// Optional stall counter output enabled by defining MAC_TANH_SEQ_PERF_EN.
module mac_tanh_sequencer #(
  parameter int unsigned        ADDR_W   = mac_tanh_pkg::ADDR_W,
  parameter int unsigned        VEC_LEN  = 16,
  parameter int unsigned        NUM_ROWS = 16,
  parameter int unsigned        NUM_VECS = 16,
  parameter logic [ADDR_W-1:0]  X_BASE   = mac_tanh_pkg::X_BASE_DEF,
  parameter logic [ADDR_W-1:0]  G_BASE   = mac_tanh_pkg::G_BASE_DEF,
  parameter logic [ADDR_W-1:0]  OUT_BASE = mac_tanh_pkg::OUT_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_rd_addr,
  output logic [ADDR_W-1:0] gmem_rd_addr,
  output logic              mac_en,
  output logic              mac_clear,
  output logic              tanh_start,
  input  logic              tanh_done,
  input  logic [15:0]       tanh_result,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic [15:0]       sram_wr_data
`ifdef MAC_TANH_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_stall_cycles
`endif
);
  import mac_tanh_pkg::*;

  state_e      state_q, state_d;
  logic        cnt_clr, k_step, row_next;
  logic        k_first, k_last, r_last, v_last;
  logic        mac_en_q, mac_clear_q;
  logic [15:0] wr_data_q;

  mac_tanh_addr_gen #(
    .ADDR_W   (ADDR_W),
    .VEC_LEN  (VEC_LEN),
    .NUM_ROWS (NUM_ROWS),
    .NUM_VECS (NUM_VECS),
    .X_BASE   (X_BASE),
    .G_BASE   (G_BASE),
    .OUT_BASE (OUT_BASE)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .cnt_clr      (cnt_clr),
    .k_step       (k_step),
    .row_next     (row_next),
    .k_first      (k_first),
    .k_last       (k_last),
    .r_last       (r_last),
    .v_last       (v_last),
    .sram_rd_addr (sram_rd_addr),
    .gmem_rd_addr (gmem_rd_addr),
    .sram_wr_addr (sram_wr_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    k_step   = 1'b0;
    row_next = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          cnt_clr = 1'b1;
        end
      end
      StFetch: begin
        if (k_last) state_d = StDrain;
        else        k_step  = 1'b1;
      end
      StDrain:    state_d = StTanhReq;
      StTanhReq:  state_d = StWaitTanh;
      StWaitTanh: if (tanh_done) state_d = StWrite;
      StWrite: begin
        if (r_last && v_last) begin
          state_d = StDone;
        end else begin
          state_d  = StFetch;
          row_next = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    tanh_start = 1'b0;
    sram_wr_en = 1'b0;
    unique case (state_q)
      StFetch, StDrain, StWaitTanh: busy = 1'b1;
      StTanhReq: begin
        busy       = 1'b1;
        tanh_start = 1'b1;
      end
      StWrite: begin
        busy       = 1'b1;
        sram_wr_en = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Read data returns one cycle after each FETCH, so the MAC strobes lag the state by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_en_q    <= 1'b0;
      mac_clear_q <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      mac_en_q    <= (state_q == StFetch);
      mac_clear_q <= (state_q == StFetch) && k_first;
      if (state_q == StWaitTanh && tanh_done) wr_data_q <= tanh_result;
    end
  end

  assign mac_en       = mac_en_q;
  assign mac_clear    = mac_clear_q;
  assign sram_wr_data = wr_data_q;

`ifdef MAC_TANH_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == StIdle && run) begin
      perf_q <= '0;
    end else if (state_q == StWaitTanh && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mac_tanh_sequencer.sv
// Directed bench: small 2x1x1 job cycle-by-cycle, default 16x16x16 job write ordering.
module tb_mac_tanh_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- small instance: VEC_LEN=2, NUM_ROWS=1, NUM_VECS=1 ----------------
  logic        a_reset, a_run, a_busy, a_done, a_mac_en, a_mac_clear, a_tanh_start, a_wr_en;
  logic        a_resp_done, a_spur, a_resp_en;
  logic [11:0] a_rd_addr, a_g_addr, a_wr_addr;
  logic [15:0] a_tanh_result, a_wr_data;
  wire         a_tanh_done = a_resp_done | a_spur;
  int          a_lat = 3;
  int          a_wr_cnt = 0;
`ifdef MAC_TANH_SEQ_PERF_EN
  logic [15:0] a_perf;
`endif

  mac_tanh_sequencer #(
    .VEC_LEN  (2),
    .NUM_ROWS (1),
    .NUM_VECS (1)
  ) dut_a (
    .clk          (clk),
    .reset        (a_reset),
    .run          (a_run),
    .busy         (a_busy),
    .done         (a_done),
    .sram_rd_addr (a_rd_addr),
    .gmem_rd_addr (a_g_addr),
    .mac_en       (a_mac_en),
    .mac_clear    (a_mac_clear),
    .tanh_start   (a_tanh_start),
    .tanh_done    (a_tanh_done),
    .tanh_result  (a_tanh_result),
    .sram_wr_en   (a_wr_en),
    .sram_wr_addr (a_wr_addr),
    .sram_wr_data (a_wr_data)
`ifdef MAC_TANH_SEQ_PERF_EN
    ,
    .perf_stall_cycles (a_perf)
`endif
  );

  initial begin
    a_resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (a_resp_en && a_tanh_start === 1'b1) begin
        repeat (a_lat) @(negedge clk);
        a_resp_done = 1'b1;
        @(negedge clk);
        a_resp_done = 1'b0;
      end
    end
  end

  always @(negedge clk) if (a_wr_en === 1'b1) a_wr_cnt++;

  // ---------------- default instance: 16 x 16 x 16 ----------------
  logic        b_reset, b_run, b_busy, b_done, b_mac_en, b_mac_clear, b_tanh_start, b_wr_en;
  logic        b_tanh_done;
  logic [11:0] b_rd_addr, b_g_addr, b_wr_addr, b_x_prev, b_g_prev;
  logic [15:0] b_tanh_result, b_wr_data;
  int          b_wr_cnt = 0;
`ifdef MAC_TANH_SEQ_PERF_EN
  logic [15:0] b_perf;
`endif

  mac_tanh_sequencer dut_b (
    .clk          (clk),
    .reset        (b_reset),
    .run          (b_run),
    .busy         (b_busy),
    .done         (b_done),
    .sram_rd_addr (b_rd_addr),
    .gmem_rd_addr (b_g_addr),
    .mac_en       (b_mac_en),
    .mac_clear    (b_mac_clear),
    .tanh_start   (b_tanh_start),
    .tanh_done    (b_tanh_done),
    .tanh_result  (b_tanh_result),
    .sram_wr_en   (b_wr_en),
    .sram_wr_addr (b_wr_addr),
    .sram_wr_data (b_wr_data)
`ifdef MAC_TANH_SEQ_PERF_EN
    ,
    .perf_stall_cycles (b_perf)
`endif
  );

  // One-cycle tanh latency responder
  initial begin
    b_tanh_done   = 1'b0;
    b_tanh_result = 16'h0;
    forever begin
      @(negedge clk);
      if (b_tanh_start === 1'b1) begin
        @(negedge clk);
        b_tanh_done   = 1'b1;
        b_tanh_result = 16'(b_wr_cnt);
        @(negedge clk);
        b_tanh_done = 1'b0;
      end
    end
  end

  // First element of each row: x restarts at 32*v, g at 32*r; writes in order from 0x200.
  always @(negedge clk) begin
    if (b_mac_en === 1'b1 && b_mac_clear === 1'b1) begin
      check_eq("b x row start", 32'(b_x_prev), 32'((b_wr_cnt / 16) * 32));
      check_eq("b g row start", 32'(b_g_prev), 32'((b_wr_cnt % 16) * 32));
    end
    if (b_wr_en === 1'b1) begin
      check_eq("b wr addr", 32'(b_wr_addr), 32'(12'h200 + 2 * b_wr_cnt));
      check_eq("b wr data", 32'(b_wr_data), 32'(b_wr_cnt));
      b_wr_cnt++;
    end
    b_x_prev = b_rd_addr;
    b_g_prev = b_g_addr;
  end

`ifdef MAC_TANH_SEQ_PERF_EN
  // ---------------- perf instance: VEC_LEN=2, NUM_ROWS=2, NUM_VECS=1 ----------------
  logic        c_reset, c_run, c_busy, c_done, c_mac_en, c_mac_clear, c_tanh_start, c_wr_en;
  logic        c_tanh_done;
  logic [11:0] c_rd_addr, c_g_addr, c_wr_addr;
  logic [15:0] c_wr_data, c_perf;

  mac_tanh_sequencer #(
    .VEC_LEN  (2),
    .NUM_ROWS (2),
    .NUM_VECS (1)
  ) dut_c (
    .clk               (clk),
    .reset             (c_reset),
    .run               (c_run),
    .busy              (c_busy),
    .done              (c_done),
    .sram_rd_addr      (c_rd_addr),
    .gmem_rd_addr      (c_g_addr),
    .mac_en            (c_mac_en),
    .mac_clear         (c_mac_clear),
    .tanh_start        (c_tanh_start),
    .tanh_done         (c_tanh_done),
    .tanh_result       (16'h0777),
    .sram_wr_en        (c_wr_en),
    .sram_wr_addr      (c_wr_addr),
    .sram_wr_data      (c_wr_data),
    .perf_stall_cycles (c_perf)
  );

  initial begin
    c_tanh_done = 1'b0;
    forever begin
      @(negedge clk);
      if (c_tanh_start === 1'b1) begin
        repeat (5) @(negedge clk);
        c_tanh_done = 1'b1;
        @(negedge clk);
        c_tanh_done = 1'b0;
      end
    end
  end
`endif

  // Small job from an IDLE negedge; flags are {busy, mac_en, mac_clear, tanh_start, wr_en, done}.
  task automatic run_small(input logic [15:0] result, input bit spur, input bit hold);
    logic [5:0] exp_tab [1:9];
    int         wc0;
    bit         seen;
    exp_tab = '{6'b100000, 6'b111000, 6'b110000, 6'b100100, 6'b100000,
                6'b100000, 6'b100000, 6'b100010, 6'b000001};
    wc0           = a_wr_cnt;
    a_tanh_result = result;
    a_run         = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check_eq($sformatf("a c%0d flags", c),
               32'({a_busy, a_mac_en, a_mac_clear, a_tanh_start, a_wr_en, a_done}),
               32'(exp_tab[c]));
      if (c == 1) begin
        check_eq("a rd addr k0", 32'(a_rd_addr), 32'h000);
        check_eq("a g addr k0", 32'(a_g_addr), 32'h000);
        if (!hold) a_run = 1'b0;
        if (spur) begin
          a_spur        = 1'b1;
          a_tanh_result = 16'hDEAD;
        end
      end
      if (c == 2) begin
        check_eq("a rd addr k1", 32'(a_rd_addr), 32'h002);
        check_eq("a g addr k1", 32'(a_g_addr), 32'h002);
        a_spur        = 1'b0;
        a_tanh_result = result;
      end
      if (c == 8) begin
        check_eq("a wr addr", 32'(a_wr_addr), 32'h200);
        check_eq("a wr data", 32'(a_wr_data), 32'(result));
      end
    end
    @(negedge clk);
    check_eq("a idle after done", 32'(a_busy), 32'h0);
    if (hold) begin
      @(negedge clk);
      check_eq("a held run restarts", 32'({a_busy, a_rd_addr}), 32'h1000);
      a_run = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (a_done === 1'b1) seen = 1'b1;
      end
      check_eq("a second job done", 32'(seen), 32'h1);
      @(negedge clk);
    end
    check_eq("a write count", 32'(a_wr_cnt - wc0), hold ? 32'd2 : 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int  wc0;
    int  done_cyc;
    a_reset = 1'b1; a_run = 1'b0; a_spur = 1'b0; a_resp_en = 1'b1; a_tanh_result = '0;
    b_reset = 1'b1; b_run = 1'b0;
`ifdef MAC_TANH_SEQ_PERF_EN
    c_reset = 1'b1; c_run = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_reset = 1'b0;
    b_reset = 1'b0;
`ifdef MAC_TANH_SEQ_PERF_EN
    c_reset = 1'b0;
`endif
    check_eq("a reset flags", 32'({a_busy, a_mac_en, a_mac_clear, a_tanh_start, a_wr_en, a_done}),
             32'h0);
    check_eq("a reset addrs", {a_rd_addr, a_g_addr, 8'h00}, 32'h0);
    check_eq("a reset wr", 32'({a_wr_addr, a_wr_data}), 32'h0);
    check_eq("b reset wr", 32'({b_wr_addr, b_wr_data}), 32'h0);
    check_eq("b reset flags", 32'({b_busy, b_mac_en, b_tanh_start, b_wr_en, b_done}), 32'h0);

    // Minimal job, then one with a spurious tanh_done during FETCH
    run_small(16'h1234, 1'b0, 1'b0);
    run_small(16'h2222, 1'b1, 1'b0);

    // Reset in WAIT_TANH, followed by a tanh_done that must not write
    wc0       = a_wr_cnt;
    a_resp_en = 1'b0;
    a_run     = 1'b1;
    @(negedge clk);
    a_run = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("a in wait", 32'({a_busy, a_tanh_start, a_mac_en}), 32'h4);
    a_reset = 1'b1;
    @(negedge clk);
    check_eq("a mid reset flags",
             32'({a_busy, a_mac_en, a_mac_clear, a_tanh_start, a_wr_en, a_done}), 32'h0);
    check_eq("a mid reset addrs", {a_rd_addr, a_g_addr, 8'h00}, 32'h0);
    check_eq("a mid reset wr", 32'({a_wr_addr, a_wr_data}), 32'h0);
    a_reset       = 1'b0;
    a_spur        = 1'b1;
    a_tanh_result = 16'hBAD0;
    @(negedge clk);
    a_spur = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("a no write after reset", 32'(a_wr_cnt - wc0), 32'd0);
    check_eq("a idle after reset", 32'({a_busy, a_wr_data}), 32'h0);
    a_resp_en = 1'b1;
    run_small(16'h5A5A, 1'b0, 1'b0);

    // run held high across the whole job, then a second job
    run_small(16'h0F0F, 1'b0, 1'b1);

    // Default-size job: 256 rows of 16 + 3 + 1 cycles, DONE 5121 cycles after run
    b_run    = 1'b1;
    done_cyc = 0;
    for (int i = 1; i <= 6000 && done_cyc == 0; i++) begin
      @(negedge clk);
      if (i == 1) b_run = 1'b0;
      if (b_done === 1'b1) done_cyc = i;
    end
    check_eq("b done cycle", 32'(done_cyc), 32'd5121);
    check_eq("b busy at done", 32'(b_busy), 32'h0);
    repeat (2) @(negedge clk);
    check_eq("b write count", 32'(b_wr_cnt), 32'd256);

`ifdef MAC_TANH_SEQ_PERF_EN
    c_run    = 1'b1;
    done_cyc = 0;
    for (int i = 1; i <= 200 && done_cyc == 0; i++) begin
      @(negedge clk);
      if (i == 1) c_run = 1'b0;
      if (c_done === 1'b1) done_cyc = i;
    end
    check_eq("c done seen", 32'(done_cyc != 0), 32'h1);
    @(negedge clk);
    check_eq("c perf stall", 32'(c_perf), 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
